sc_request_arbiter: RTL

// Round-robin arbiter sharing the slow-control TX FIFO write port among NUM_REQ requesters.
// - Each requester presents a 56-bit command payload; the winner's payload gets the 8'h7E header and goes to the FIFO.
// - The frame is written only when the FIFO is neither full nor write-busy.
// - Sits between the software/register requesters and the slow-control FIFO; the FIFO read side is unaffected.

---
 rtl/sc_request_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sc_request_arbiter.sv
// sc_request_arbiter
// Round-robin arbiter for the slow-control TX FIFO write port. Each cycle
// in IDLE it searches the requesters starting just after the last winner.
// It latches the winner's 56-bit command behind a fixed header byte, then
// waits in WRITE until the FIFO can take the frame. If the FIFO stays
// blocked too long, the frame is dropped.
module sc_request_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter logic [7:0]  HEADER    = 8'h7E,
    parameter int          STALL_MAX = 1023,
    parameter int          CNT_W     = 16,
    localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*56-1:0]   req_payload,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      req_err,
    output logic [63:0]             fifo_di,
    output logic                    fifo_wren,
    input  logic                    fifo_full,
    input  logic                    fifo_wrbusy,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        frames_written,
    output logic                    stall_timeout
);

    localparam int STALL_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // One-hot decode of a requester index, used for ack/err pulses.
    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_id_q, grant_id_d;
    logic [63:0]          fifo_di_q, fifo_di_d;
    logic                 fifo_wren_q, fifo_wren_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]   req_err_q, req_err_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [STALL_W-1:0]   stall_inc;
    logic [CNT_W-1:0]     frames_q, frames_d;
    logic                 stall_to_q, stall_to_d;

    logic                 rr_hit;
    logic [IDX_W-1:0]     rr_pick;
    logic [55:0]          payload_arr [NUM_REQ];

    // Slice the flat payload bus into one command per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_payload
        assign payload_arr[g] = req_payload[56*g +: 56];
    end

    // Round-robin search: first active requester after the last winner.
    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int               cand;
            logic [IDX_W-1:0] cand_idx;
            cand     = (int'(rr_ptr_q) + k) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!rr_hit && req_valid[cand_idx]) begin
                rr_hit  = 1'b1;
                rr_pick = cand_idx;
            end
        end
    end

    assign stall_inc = stall_cnt_q + STALL_W'(1);

    // Next-state logic: grant in IDLE, write or stall-count in WRITE.
    // A flush overrides everything and leaves pointer and counters alone.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        fifo_di_d   = fifo_di_q;
        fifo_wren_d = 1'b0;
        req_ack_d   = '0;
        req_err_d   = '0;
        stall_cnt_d = stall_cnt_q;
        frames_d    = frames_q;
        stall_to_d  = stall_to_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rr_hit) begin
                        grant_id_d  = rr_pick;
                        fifo_di_d   = {HEADER, payload_arr[rr_pick]};
                        stall_cnt_d = '0;
                        state_d     = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!fifo_full && !fifo_wrbusy) begin
                        fifo_wren_d = 1'b1;
                        req_ack_d   = idx_onehot(grant_id_q);
                        rr_ptr_d    = grant_id_q;
                        frames_d    = frames_q + CNT_W'(1);
                        state_d     = ST_IDLE;
                    end else begin
                        stall_cnt_d = stall_inc;
                        // Give up on this frame once the FIFO has blocked long enough.
                        if (stall_inc == STALL_W'(STALL_MAX)) begin
                            req_err_d  = idx_onehot(grant_id_q);
                            stall_to_d = 1'b1;
                            rr_ptr_d   = grant_id_q;
                            state_d    = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset puts every output at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            grant_id_q  <= '0;
            fifo_di_q   <= '0;
            fifo_wren_q <= 1'b0;
            req_ack_q   <= '0;
            req_err_q   <= '0;
            stall_cnt_q <= '0;
            frames_q    <= '0;
            stall_to_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            fifo_di_q   <= fifo_di_d;
            fifo_wren_q <= fifo_wren_d;
            req_ack_q   <= req_ack_d;
            req_err_q   <= req_err_d;
            stall_cnt_q <= stall_cnt_d;
            frames_q    <= frames_d;
            stall_to_q  <= stall_to_d;
        end
    end

    assign req_ack        = req_ack_q;
    assign req_err        = req_err_q;
    assign fifo_di        = fifo_di_q;
    assign fifo_wren      = fifo_wren_q;
    assign grant_id       = grant_id_q;
    assign busy           = (state_q == ST_WRITE);
    assign frames_written = frames_q;
    assign stall_timeout  = stall_to_q;

    // Ack and err together carry at most one set bit; wren tracks ack.
    a_pulse_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0({req_ack_q, req_err_q}));
    a_wren_ack: assert property (@(posedge clk) disable iff (rst)
        fifo_wren_q == (|req_ack_q));

endmodule
